irq_controller: RTL

Parametrised, memory-mapped interrupt controller replacing the single-source keyboard interrupt latch at the board top level. It accepts `N_SRC` interrupt request lines, latches edge- or level-type events per source, masks them, and presents the highest-priority pending source to the `riscv64` core on `interrupt_vector`. The vector is held stable until `interrupt_ack`. It sits on the CPU data bus beside the UART and keyboard decode, so software can inspect and clear pending state and program masks.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 35 +++
 rtl/irq_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
//   Shared definitions for the interrupt controller:
//     - register word offsets as decoded from bus_address
//     - FSM state encoding used by irq_controller
// -----------------------------------------------------------------------------
package irq_pkg;

    // Register word offsets (bus_address values)
    localparam logic [1:0] IRQ_REG_PENDING = 2'd0;
    localparam logic [1:0] IRQ_REG_ENABLE  = 2'd1;
    localparam logic [1:0] IRQ_REG_TRIGGER = 2'd2;
    localparam logic [1:0] IRQ_REG_OVERRUN = 2'd3;

    // Vector presentation FSM
    typedef enum logic [1:0] {
        IDLE     = 2'd0,  // no vector presented, waiting for a masked-pending source
        ASSERT   = 2'd1,  // vector held stable until acknowledged
        ACK_WAIT = 2'd2   // waiting for ack to drop before arbitrating again
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
//   Combinational lowest-index-first priority encoder.
//
// Parameters:
//   N_SRC  number of request lines
//   IDX_W  width of the index output
//
// Ports:
//   req  in   [N_SRC-1:0]  request vector
//   any  out               at least one request is set
//   idx  out  [IDX_W-1:0]  index of the lowest set request (0 when none)
// -----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 4
) (
    input  logic [N_SRC-1:0] req,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set index is the last to overwrite.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                any = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//   Memory-mapped interrupt controller. Latches edge- or level-type events per
//   source, masks them, and presents the lowest-index masked-pending source on
//   interrupt_vector (index + 1; 0 = none). The vector is held until acked, and
//   a further vector is only presented once ack has dropped again.
//
// Registers (bus_address):
//   0 PENDING  read, write-1-to-clear
//   1 ENABLE   read/write
//   2 TRIGGER  read/write, 1 = rising edge, 0 = level (resets to all ones)
//   3 OVERRUN  sticky W1C overrun flags when IRQ_OVERRUN_EN is defined,
//              otherwise reads 0 and ignores writes
//
// Configuration macro: IRQ_OVERRUN_EN
//
// Ports:
//   clk               in   single clock, rising edge
//   reset             in   synchronous active-high reset
//   irq_src           in   [N_SRC-1:0] request lines (clk domain)
//   interrupt_vector  out  [VEC_W-1:0] presented vector
//   interrupt_ack     in   CPU acknowledge of the current vector
//   bus_address       in   [1:0] register word select
//   bus_write_enable  in   register write strobe
//   bus_write_data    in   [DATA_W-1:0] write data (bits [N_SRC-1:0] used)
//   bus_read_enable   in   register read strobe
//   bus_read_data     out  [DATA_W-1:0] registered read data
// -----------------------------------------------------------------------------
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int VEC_W  = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_src,
    output logic [VEC_W-1:0]  interrupt_vector,
    input  logic              interrupt_ack,
    input  logic [1:0]        bus_address,
    input  logic              bus_write_enable,
    input  logic [DATA_W-1:0] bus_write_data,
    input  logic              bus_read_enable,
    output logic [DATA_W-1:0] bus_read_data
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  enable_q,  enable_d;
    logic [N_SRC-1:0]  trigger_q, trigger_d;
    logic [N_SRC-1:0]  irq_prev_q;
    irq_state_e        state_q,   state_d;
    logic [VEC_W-1:0]  vec_q,     vec_d;
    logic [VEC_W-1:0]  cur_idx_q, cur_idx_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;

    // -------------------------------------------------------------------------
    // Bus write decode
    // -------------------------------------------------------------------------
    logic [N_SRC-1:0] wdata_src;
    logic             wr_pending;
    logic             wr_enable;
    logic             wr_trigger;

    assign wdata_src  = bus_write_data[N_SRC-1:0];
    assign wr_pending = bus_write_enable && (bus_address == IRQ_REG_PENDING);
    assign wr_enable  = bus_write_enable && (bus_address == IRQ_REG_ENABLE);
    assign wr_trigger = bus_write_enable && (bus_address == IRQ_REG_TRIGGER);

    // Only the low N_SRC bits of write data carry register content.
    if (DATA_W > N_SRC) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^bus_write_data[DATA_W-1:N_SRC];
    end

    // Ack only retires a source while a vector is actually being presented.
    logic ack_fire;
    assign ack_fire = (state_q == ASSERT) && interrupt_ack;

    // -------------------------------------------------------------------------
    // Per-source pending logic
    // -------------------------------------------------------------------------
    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] w1c_clr;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign edge_det[gi] = irq_src[gi] & ~irq_prev_q[gi];
        assign ack_clr[gi]  = ack_fire && (cur_idx_q == VEC_W'(gi));
        assign w1c_clr[gi]  = wr_pending && wdata_src[gi];

        // Edge type: a new edge beats any clear in the same cycle.
        // Level type: pending simply follows the line; clears do not stick.
        assign pending_d[gi] = trigger_q[gi]
                             ? (edge_det[gi] | (pending_q[gi] & ~(ack_clr[gi] | w1c_clr[gi])))
                             : irq_src[gi];
    end

    assign enable_d  = wr_enable  ? wdata_src : enable_q;
    assign trigger_d = wr_trigger ? wdata_src : trigger_q;

    // -------------------------------------------------------------------------
    // Overrun flags
    // -------------------------------------------------------------------------
    logic [N_SRC-1:0] overrun_rd;

`ifdef IRQ_OVERRUN_EN
    logic [N_SRC-1:0] overrun_q, overrun_d;
    logic [N_SRC-1:0] overrun_set;
    logic             wr_overrun;

    assign wr_overrun = bus_write_enable && (bus_address == IRQ_REG_OVERRUN);

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ovr
        // An edge lands on an already-pending edge source that is not being
        // retired this cycle: the earlier event is merged and lost.
        assign overrun_set[gi] = trigger_q[gi] & edge_det[gi] & pending_q[gi]
                               & ~(ack_clr[gi] | w1c_clr[gi]);
        // A fresh overrun wins over a simultaneous W1C so it is never missed.
        assign overrun_d[gi]   = overrun_set[gi]
                               | (overrun_q[gi] & ~(wr_overrun & wdata_src[gi]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_rd = overrun_q;
`else
    assign overrun_rd = '0;
`endif

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [N_SRC-1:0] masked;
    logic             enc_any;
    logic [VEC_W-1:0] enc_idx;

    assign masked = pending_q & enable_q;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .IDX_W (VEC_W)
    ) u_prio_enc (
        .req (masked),
        .any (enc_any),
        .idx (enc_idx)
    );

    // -------------------------------------------------------------------------
    // Vector FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cur_idx_d = cur_idx_q;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    state_d   = ASSERT;
                    vec_d     = enc_idx + VEC_W'(1);
                    cur_idx_d = enc_idx;
                end
            end
            ASSERT: begin
                // Vector is frozen here; mask/pending changes are ignored.
                if (interrupt_ack) begin
                    state_d = ACK_WAIT;
                    vec_d   = '0;
                end
            end
            ACK_WAIT: begin
                // A held ack must not retire the next source.
                if (!interrupt_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Read data: sampled from current register state, so a same-cycle write
    // is not visible; holds its value when no read is requested.
    // -------------------------------------------------------------------------
    always_comb begin
        rdata_d = rdata_q;
        if (bus_read_enable) begin
            rdata_d = '0;
            case (bus_address)
                IRQ_REG_PENDING: rdata_d[N_SRC-1:0] = pending_q;
                IRQ_REG_ENABLE:  rdata_d[N_SRC-1:0] = enable_q;
                IRQ_REG_TRIGGER: rdata_d[N_SRC-1:0] = trigger_q;
                default:         rdata_d[N_SRC-1:0] = overrun_rd;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // Tracks the line during reset too, so a line already high at reset
        // exit is not mistaken for a rising edge.
        irq_prev_q <= irq_src;

        if (reset) begin
            pending_q <= '0;
            enable_q  <= '0;
            trigger_q <= '1;
            state_q   <= IDLE;
            vec_q     <= '0;
            cur_idx_q <= '0;
            rdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            trigger_q <= trigger_d;
            state_q   <= state_d;
            vec_q     <= vec_d;
            cur_idx_q <= cur_idx_d;
            rdata_q   <= rdata_d;
        end
    end

    assign interrupt_vector = vec_q;
    assign bus_read_data    = rdata_q;

endmodule
